// File: rtl/br_sfifo_wr_arb.sv
// Round-robin burst arbiter in front of a shared sync FIFO write port.
// Optional stall watchdog: define BR_SFIFO_WR_ARB_WDOG_EN.
module br_sfifo_wr_arb #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int PTR       = 2,
  parameter int MAX_BURST = 8,
  parameter int AF_LVL    = 12,
  parameter int WDOG_CYC  = 64
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_din,
  input  logic                  fifo_full,
  input  logic [PTR+1:0]        fifo_cnt,
  output logic                  wdog_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_BURST = 1'b1;

  logic            state;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   rr_last;
  logic [7:0]      bcnt;
  logic            acc;
  logic            last_g;
  logic            rel;
  logic            can_gnt;
  logic            pick_vld;
  logic [IW-1:0]   pick;
  logic [NREQ-1:0] pick_oh;
  logic [WIDTH-1:0] din;
  logic            wdog_fire;

  // Scan starts just past the last winner so every requester rotates.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_vld && req_vld[(int'(rr_last) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick     = IW'((int'(rr_last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    din    = '0;
    last_g = |(gnt_q & req_last);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) din = din | req_data[i*WIDTH +: WIDTH];
    end
  end

  assign acc     = |(gnt_q & req_vld) & ~fifo_full;
  assign rel     = acc && (last_g || bcnt == 8'(MAX_BURST-1));
  assign can_gnt = pick_vld && (int'(fifo_cnt) < AF_LVL);

`ifdef BR_SFIFO_WR_ARB_WDOG_EN
  logic [15:0] wcnt;

  // Only a vanished requester counts as a stall; a full FIFO never does.
  assign wdog_fire = (state == S_BURST) && !acc && !fifo_full &&
                     (wcnt == 16'(WDOG_CYC-1));

  always_ff @(posedge clk) begin
    if (srst) begin
      wcnt     <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_fire;
      if (state != S_BURST || acc || wdog_fire)
        wcnt <= '0;
      else if (!fifo_full)
        wcnt <= wcnt + 16'd1;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= S_IDLE;
      gnt_q   <= '0;
      rr_last <= IW'(NREQ-1);
      bcnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_gnt) begin
            state   <= S_BURST;
            gnt_q   <= pick_oh;
            rr_last <= pick;
            bcnt    <= '0;
          end
        end
        S_BURST: begin
          if (acc) bcnt <= bcnt + 8'd1;
          if (rel || wdog_fire) begin
            state <= S_IDLE;
            gnt_q <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state == S_BURST);
  assign fifo_wr_en = acc;
  assign fifo_din   = din;
  assign req_ack    = acc ? gnt_q : '0;

endmodule

// File: tb/tb_br_sfifo_wr_arb.sv
// Directed bench for br_sfifo_wr_arb; inputs change on the falling edge.
// Watchdog steps run only when BR_SFIFO_WR_ARB_WDOG_EN is defined.
module tb_br_sfifo_wr_arb;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           srst;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_din;
  logic           fifo_full;
  logic [3:0]     fifo_cnt;
  logic           wdog_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  br_sfifo_wr_arb #(
    .WIDTH(W), .NREQ(N), .PTR(2), .MAX_BURST(8), .AF_LVL(12), .WDOG_CYC(64)
  ) dut (
    .clk(clk), .srst(srst),
    .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .gnt(gnt), .busy(busy),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .wdog_err(wdog_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setd(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst    = 1'b1;
    req_vld = '0;
    req_last = '0;
    fifo_full = 1'b0;
    fifo_cnt = '0;
    @(negedge clk);
    srst = 1'b0;
  endtask

  initial begin
    int ord [5];
    int w;
    int grants;
    int falls;
    int per;
    logic gprev;
    logic stall;
    ord = '{0, 1, 2, 3, 0};

    // reset state
    srst = 1'b1; req_vld = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; fifo_cnt = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", fifo_wr_en, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_wdog", wdog_err, 0);

    // single requester, 3-word burst
    @(negedge clk);
    srst = 1'b0; req_vld = 4'b0010; setd(1, 32'hA000_0000);
    #1;
    chk("t1_pre_gnt", gnt, 0);
    chk("t1_pre_wr", fifo_wr_en, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      setd(1, 32'hA000_0000 + k);
      req_last = (k == 2) ? 4'b0010 : 4'b0000;
      #1;
      chk("t1_gnt", gnt, 4'b0010);
      chk("t1_busy", busy, 1);
      chk("t1_wr", fifo_wr_en, 1);
      chk("t1_din", fifo_din, 32'hA000_0000 + k);
      chk("t1_ack", req_ack, 4'b0010);
    end
    @(negedge clk);
    req_vld = '0; req_last = '0;
    #1;
    chk("t1_rel_gnt", gnt, 0);
    chk("t1_rel_busy", busy, 0);
    chk("t1_rel_wr", fifo_wr_en, 0);

    // round robin, one word per grant
    do_reset();
    req_vld = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < N; i++) setd(i, 32'hB0 + i);
    #1;
    chk("t2_pre_gnt", gnt, 0);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      #1;
      chk("t2_gnt", gnt, 4'b0001 << ord[g]);
      chk("t2_wr", fifo_wr_en, 1);
      chk("t2_din", fifo_din, 32'hB0 + ord[g]);
      @(negedge clk);
      if (g == 4) req_vld = '0;
      #1;
      chk("t2_bubble", gnt, 0);
    end

    // MAX_BURST cap: 20 words, last never set
    do_reset();
    req_vld = 4'b0100; setd(2, 0);
    w = 0; grants = 0; falls = 0; per = 0; gprev = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      req_vld = (w < 20) ? 4'b0100 : 4'b0000;
      setd(2, w);
      #1;
      if (gnt[2] && !gprev) begin grants++; per = 0; end
      if (!gnt[2] && gprev) begin chk("t3_cap", per, 8); falls++; end
      gprev = gnt[2];
      if (fifo_wr_en) begin
        chk("t3_din", fifo_din, w);
        w++; per++;
      end
    end
    chk("t3_words", w, 20);
    chk("t3_grants", grants, 3);
    chk("t3_falls", falls, 2);
    chk("t3_tail", per, 4);
    chk("t3_held", gnt, 4'b0100);

    // backpressure: full for 5 cycles mid-burst
    do_reset();
    req_vld = 4'b0001;
    w = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      stall = (c >= 2 && c < 7);
      fifo_full = stall;
      setd(0, 32'hC0 + w);
      req_last = (w == 5) ? 4'b0001 : 4'b0000;
      #1;
      chk("t4_gnt", gnt, 4'b0001);
      chk("t4_wr", fifo_wr_en, !stall);
      chk("t4_ack", req_ack, stall ? 4'b0000 : 4'b0001);
      if (fifo_wr_en) begin
        chk("t4_din", fifo_din, 32'hC0 + w);
        w++;
      end
    end
    @(negedge clk);
    fifo_full = 1'b0; req_vld = '0; req_last = '0;
    #1;
    chk("t4_words", w, 6);
    chk("t4_rel", gnt, 0);

    // almost-full throttle
    do_reset();
    fifo_cnt = 4'd12; req_vld = 4'b0001; req_last = '0;
    setd(0, 32'hD0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("t5_af_gnt", gnt, 0);
      chk("t5_af_busy", busy, 0);
    end
    @(negedge clk);
    fifo_cnt = 4'd11;
    #1;
    chk("t5_pre", gnt, 0);
    @(negedge clk);
    fifo_cnt = 4'd12;
    #1;
    chk("t5_gnt", gnt, 4'b0001);
    chk("t5_wr12", fifo_wr_en, 1);
    @(negedge clk);
    fifo_cnt = 4'd13; req_last = 4'b0001;
    #1;
    chk("t5_wr13", fifo_wr_en, 1);
    @(negedge clk);
    fifo_cnt = 4'd12; req_last = '0;
    #1;
    chk("t5_bubble", gnt, 0);
    @(negedge clk);
    #1;
    chk("t5_blocked", gnt, 0);

    // reset mid-burst
    @(negedge clk);
    fifo_cnt = '0;
    @(negedge clk);
    #1;
    chk("t6_gnt", gnt, 4'b0001);
    chk("t6_busy", busy, 1);
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wr", fifo_wr_en, 0);
    srst = 1'b0; req_vld = '0;

`ifdef BR_SFIFO_WR_ARB_WDOG_EN
    // watchdog: requester 1 vanishes mid-burst
    do_reset();
    req_vld = 4'b0110; req_last = '0;
    @(negedge clk);
    req_vld = 4'b0100;
    #1;
    chk("t7_gnt", gnt, 4'b0010);
    for (int k = 2; k <= 64; k++) begin
      @(negedge clk);
      #1;
      chk("t7_hold", gnt, 4'b0010);
      chk("t7_quiet", wdog_err, 0);
    end
    @(negedge clk);
    #1;
    chk("t7_rel", gnt, 0);
    chk("t7_pulse", wdog_err, 1);
    @(negedge clk);
    #1;
    chk("t7_pulse_end", wdog_err, 0);
    chk("t7_next", gnt, 4'b0100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
